pc_gen: RTL and testbench

- Parametrised program-counter / next-PC generator; successor to the single-width fixed-step PC.
- Sits between decode/execute (branch, jal, jalr redirects) and instruction memory (fetch request handshake).
- Adds configurable address width, step size and reset vector, stall/halt control, a fetch valid/ready handshake, a link-address output, and optional misaligned-target trapping.

---
 rtl/pc_gen.sv | 120 ++++++++++++
 tb/tb_pc_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - parametrised PC / next-PC generator with fetch handshake; optional PC_GEN_MISALIGN_TRAP_EN traps misaligned targets
module pc_gen #(
    parameter int          ADDR_W    = 10,
    parameter int          IMM_W     = 21,
    parameter int          STEP      = 4,
    parameter logic [31:0] RESET_VEC = 32'd0,
    parameter logic [31:0] TRAP_VEC  = 32'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic              branch,
    input  logic              zero_flag,
    input  logic [1:0]        jump_mode,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [31:0]       reg_out1,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] link_addr,
    output logic              redirect,
    output logic              trap,
    output logic [ADDR_W-1:0] trap_addr
);

    localparam logic [1:0] ST_BOOT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

`ifdef PC_GEN_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] RESET_A    = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] TRAP_A     = ADDR_W'(TRAP_VEC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        state_q, state_d;
    logic              redirect_q, redirect_d;
    logic              trap_q, trap_d;
    logic [ADDR_W-1:0] trap_addr_q, trap_addr_d;

    logic [31:0]       imm_sext;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              misaligned;

    assign imm_sext = 32'($signed(immediate));
    assign taken    = branch & (jump_mode[1] | zero_flag);

    // Targets are formed in 32 bits; truncation gives the modulo-2^ADDR_W wrap.
    assign target = ADDR_W'((jump_mode == 2'b11)
                            ? ((reg_out1 + imm_sext) & ~32'd1)
                            : (32'(pc_q) + imm_sext));
    assign misaligned = |(target & ALIGN_MASK);

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        redirect_d  = 1'b0;
        trap_d      = 1'b0;
        trap_addr_d = trap_addr_q;
        if (!stall) begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_HALT: begin
                    if (resume) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (taken) begin
                        redirect_d = 1'b1;
                        if (TRAP_EN && misaligned) begin
                            pc_d        = TRAP_A;
                            trap_d      = 1'b1;
                            trap_addr_d = target;
                        end else begin
                            pc_d = target & ~ALIGN_MASK;
                        end
                    end else if (!halt && fetch_ready) begin
                        pc_d = pc_q + STEP_A;
                    end
                    if (halt) state_d = ST_HALT;
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_A;
            state_q     <= ST_BOOT;
            redirect_q  <= 1'b0;
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            redirect_q  <= redirect_d;
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign pc_out      = pc_q;
    assign fetch_addr  = pc_q;
    assign fetch_valid = (state_q == ST_RUN);
    assign link_addr   = pc_q + STEP_A;
    assign redirect    = redirect_q;
    assign trap        = trap_q;
    assign trap_addr   = trap_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen against a behavioural next-PC model
module tb_pc_gen;

    localparam int ADDR_W = 10;
    localparam int IMM_W  = 21;
    localparam int STEP   = 4;
    localparam int MASK   = (1 << ADDR_W) - 1;
    localparam int TRAPV  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0, halt = 1'b0, resume = 1'b0;
    logic              branch = 1'b0, zero_flag = 1'b0;
    logic [1:0]        jump_mode = 2'b00;
    logic [IMM_W-1:0]  immediate = '0;
    logic [31:0]       reg_out1 = '0;
    logic              fetch_ready = 1'b1;
    logic [ADDR_W-1:0] pc_out, fetch_addr, link_addr, trap_addr;
    logic              fetch_valid, redirect, trap;

    pc_gen #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .STEP(STEP),
             .RESET_VEC(32'd0), .TRAP_VEC(32'd4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
        .branch(branch), .zero_flag(zero_flag), .jump_mode(jump_mode),
        .immediate(immediate), .reg_out1(reg_out1), .fetch_ready(fetch_ready),
        .pc_out(pc_out), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .link_addr(link_addr), .redirect(redirect), .trap(trap), .trap_addr(trap_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = boot, 1 = running, 2 = halted
    int m_pc, m_st, m_trap_addr;
    bit m_redir, m_trap;

    function automatic int sext(input logic [IMM_W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_st = 0; m_redir = 0; m_trap = 0; m_trap_addr = 0;
    endfunction

    function automatic void model_edge();
        bit taken;
        int t;
        m_redir = 0;
        m_trap  = 0;
        if (stall) return;
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 2) begin
            if (resume) m_st = 1;
        end else begin
            taken = branch && ((jump_mode == 2'b10 || jump_mode == 2'b11) ? 1'b1 : zero_flag);
            if (taken) begin
                if (jump_mode == 2'b11) t = (int'(reg_out1) + sext(immediate)) & ~1;
                else                    t = m_pc + sext(immediate);
                t = t & MASK;
`ifdef PC_GEN_MISALIGN_TRAP_EN
                if (t % STEP != 0) begin
                    m_pc = TRAPV; m_trap = 1; m_trap_addr = t;
                end else begin
                    m_pc = t;
                end
`else
                m_pc = t - (t % STEP);
`endif
                m_redir = 1;
            end else if (!halt && fetch_ready) begin
                m_pc = (m_pc + STEP) & MASK;
            end
            if (halt) m_st = 2;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".pc_out"},      32'(pc_out),      32'(m_pc));
        check({ctx, ".fetch_addr"},  32'(fetch_addr),  32'(m_pc));
        check({ctx, ".fetch_valid"}, 32'(fetch_valid), 32'(m_st == 1));
        check({ctx, ".link_addr"},   32'(link_addr),   32'((m_pc + STEP) & MASK));
        check({ctx, ".redirect"},    32'(redirect),    32'(m_redir));
        check({ctx, ".trap"},        32'(trap),        32'(m_trap));
        check({ctx, ".trap_addr"},   32'(trap_addr),   32'(m_trap_addr));
    endtask

    task automatic tick(input string ctx);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(ctx);
    endtask

    task automatic idle();
        stall = 0; halt = 0; resume = 0; branch = 0; zero_flag = 0;
        jump_mode = 2'b00; immediate = '0; reg_out1 = '0; fetch_ready = 1;
    endtask

    task automatic do_reset(input string ctx);
        reset = 1;
        #1;
        model_reset();
        check_outputs(ctx);
        #1;
        reset = 0;
    endtask

    task automatic goto_pc(input int a);
        idle();
        branch = 1; jump_mode = 2'b11; reg_out1 = 32'(a);
        tick("goto");
        idle();
    endtask

    initial begin
        idle();
        #12;
        model_reset();
        check_outputs("reset");
        reset = 0;
        tick("boot");
        check("boot_valid_const", 32'(fetch_valid), 32'd1);
        for (int i = 0; i < 3; i++) tick("seq");
        check("seq_pc_const", 32'(pc_out), 32'd12);

        // Mid-run reset, including a pending redirect on the inputs
        branch = 1; jump_mode = 2'b10; immediate = 21'd40;
        do_reset("rst_mid");
        idle();
        tick("reboot");
        for (int i = 0; i < 2; i++) tick("seq2");

        goto_pc(8);
        fetch_ready = 0;
        for (int i = 0; i < 3; i++) tick("bp");
        check("bp_hold_const", 32'(pc_out), 32'd8);
        fetch_ready = 1;
        stall = 1; branch = 1; jump_mode = 2'b10; immediate = 21'd40;
        tick("stall");
        check("stall_pc_const", 32'(pc_out), 32'd8);
        check("stall_redir_const", 32'(redirect), 32'd0);

        goto_pc(16);
        branch = 1; zero_flag = 1; jump_mode = 2'b00; immediate = -21'sd8;
        tick("beq_taken");
        check("beq_pc_const", 32'(pc_out), 32'd8);
        check("beq_redir_const", 32'(redirect), 32'd1);

        goto_pc(16);
        branch = 1; zero_flag = 0; jump_mode = 2'b01; immediate = -21'sd8;
        tick("beq_not");
        check("bne_pc_const", 32'(pc_out), 32'd20);

        goto_pc(16);
        check("jal_link_const", 32'(link_addr), 32'd20);
        branch = 1; jump_mode = 2'b10; immediate = 21'd40;
        tick("jal");
        check("jal_pc_const", 32'(pc_out), 32'd56);

        idle();
        branch = 1; jump_mode = 2'b11; reg_out1 = 32'h101; immediate = 21'd2;
        tick("jalr");

        goto_pc(1020);
        tick("wrap");
        check("wrap_pc_const", 32'(pc_out), 32'd0);

        goto_pc(24);
        halt = 1;
        tick("halt");
        check("halt_pc_const", 32'(pc_out), 32'd24);
        check("halt_valid_const", 32'(fetch_valid), 32'd0);
        tick("halt_hold");
        halt = 0; resume = 1;
        tick("resume");
        resume = 0;
        tick("after_resume");
        check("resume_pc_const", 32'(pc_out), 32'd28);

        goto_pc(0);
        branch = 1; jump_mode = 2'b10; immediate = 21'd6;
        tick("misalign");
        check("misalign_pc_const", 32'(pc_out), 32'd4);
`ifdef PC_GEN_MISALIGN_TRAP_EN
        check("misalign_trap_const", 32'(trap), 32'd1);
        check("misalign_taddr_const", 32'(trap_addr), 32'd6);
`else
        check("misalign_trap_const", 32'(trap), 32'd0);
`endif
        idle();
        tick("post_misalign");

        // Reset while halted with a redirect pending
        halt = 1;
        tick("halt2");
        branch = 1; jump_mode = 2'b10; immediate = 21'd12;
        do_reset("rst_halt");
        idle();
        tick("reboot2");

        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 9) == 0);
            halt        = ($urandom_range(0, 19) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            branch      = ($urandom_range(0, 2) == 0);
            zero_flag   = 1'($urandom);
            jump_mode   = 2'($urandom);
            immediate   = IMM_W'($urandom_range(0, 511)) - IMM_W'(256);
            reg_out1    = $urandom;
            fetch_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
